mem_access_unit: RTL and testbench
==================================

// Module: mem_access_unit
// PURPOSE
//   Parametrised MAR/MDR memory-access unit for the bus datapath. Replaces the fixed
//   single-cycle MDR-mux/RAM coupling with a req/ack handshake, so memories of any
//   latency can attach. Adds busy/done status for the control unit and a timeout
//   error. Sits between the shared datapath bus and the memory port.
// PARAMETERS
//   DATA_W       32   width of bus, MDR and memory data
//   ADDR_W        9   width of MAR and mem_addr; MAR loads bus_in[ADDR_W-1:0]
//   TIMEOUT_CYC  16   max cycles in ACCESS without ack; 0 disables timeout
// PORTS
//   clk        in   1       system clock, rising edge
//   clr        in   1       asynchronous reset, active-high
//   bus_in     in   DATA_W  datapath bus
//   MARin      in   1       load MAR from bus_in (ignored while busy)
//   MDRin      in   1       load MDR from bus_in (ignored while busy)
//   read       in   1       start read of MEM[MAR] into MDR (1-cycle pulse)
//   write      in   1       start write of MDR to MEM[MAR] (1-cycle pulse)
//   err_clr    in   1       clear sticky err
//   mar_q      out  ADDR_W  MAR contents
//   mdr_q      out  DATA_W  MDR contents; drives MDRout leg of bus mux
//   busy       out  1       access in progress (state==ACCESS)
//   done       out  1       1-cycle pulse: access finished (ack or timeout)
//   err        out  1       sticky: an access timed out
//   mem_req    out  1       request; held high until ack or timeout
//   mem_we     out  1       1=write, 0=read; stable while mem_req
//   mem_addr   out  ADDR_W  address; stable while mem_req
//   mem_wdata  out  DATA_W  write data; stable while mem_req
//   mem_rdata  in   DATA_W  read data; valid in the cycle mem_ack=1
//   mem_ack    in   1       memory completes access this cycle
// BEHAVIOUR
//   - Reset (clr=1, async): every output and register 0; state IDLE; mem_req drops
//     immediately, even mid-access. No done pulse for a reset-aborted access.
//   - FSM: IDLE -> ACCESS on read|write. ACCESS -> IDLE on mem_ack, or when wait
//     counter == TIMEOUT_CYC-1 (TIMEOUT_CYC>0). Both exits assert done next cycle.
//   - Issue edge N: mem_req/mem_we/mem_addr/mem_wdata registered; high from cycle N+1.
//   - Command forwarding: at issue, addr = MARin ? bus_in[ADDR_W-1:0] : mar_q and
//     wdata = MDRin ? bus_in : mdr_q; MAR/MDR also take the bus value that edge.
//   - read and write same cycle: read wins, write dropped.
//   - read/write/MARin/MDRin while busy: ignored. MAR, MDR frozen during ACCESS.
//   - Read ack at edge M: mdr_q <= mem_rdata, mem_req -> 0, done=1 in cycle M+1.
//     Minimum command-to-done latency 2 cycles (ack in first req cycle).
//   - Write ack: MDR unchanged; same timing.
//   - Timeout: err sticky 1, mem_req -> 0, MDR unchanged, done pulses. err cleared
//     only by clr or err_clr; err_clr in the same cycle as a timeout: err stays 1.
//   - mem_ack in IDLE: ignored. Wait counter resets to 0 on every ACCESS entry.
//   - done is 1 for exactly one cycle; a new command may issue in the done cycle.
// STRUCTURE
//   - State encodings (ST_IDLE=1'b0, ST_ACCESS=1'b1) and the default widths live in
//     the shared include datapath_defs.vh, used by datapath and control unit.
//   - One sub-module: mem_wait_counter (clear/enable, width $clog2(TIMEOUT_CYC+1),
//     terminal-count output). All other logic stays inline.
// TESTING
//   - Read, ack in 1st req cycle: MAR=0x05, MEM[5]=0xDEADBEEF -> mdr_q=0xDEADBEEF,
//     done in cycle N+2, busy high only in cycle N+1.
//   - Write, ack after 3 wait cycles: MDR=0x12345678, MAR=0x1F0 -> mem_we=1,
//     mem_addr=0x1F0, mem_wdata stable 4 cycles; single done pulse.
//   - Forwarding: MARin+read same cycle, bus_in=0x0A -> mem_addr=0x0A, mar_q=0x0A.
//   - Timeout TIMEOUT_CYC=4, no ack -> mem_req high 4 cycles, err=1, done pulse,
//     MDR unchanged; err_clr -> err=0.
//   - Busy lockout: MDRin with bus_in=0xFFFFFFFF and a 2nd read mid-access -> MDR
//     and mem_addr unchanged, exactly one done.
//   - clr mid-access: mem_req=0 same cycle, no done, all outputs 0; next read works.

Source files
------------

// File: rtl/mem_access_unit_pkg.sv
// Shared types and defaults for the MAR/MDR memory-access unit.
// The state encoding is shared with the datapath and the control unit.
package mem_access_unit_pkg;

   typedef enum logic {
      StIdle   = 1'b0,
      StAccess = 1'b1
   } state_e;

   localparam int unsigned DefDataW      = 32;
   localparam int unsigned DefAddrW      = 9;
   localparam int unsigned DefTimeoutCyc = 16;

   // Counter width for a given timeout; kept at least 1 bit when the timeout is disabled
   function automatic int unsigned wait_cnt_width(input int unsigned timeout_cyc);
      return (timeout_cyc == 0) ? 1 : $clog2(timeout_cyc + 1);
   endfunction

endpackage

// File: rtl/mem_access_unit_if.sv
// Memory-port handshake between the access unit (master) and a memory of any latency (slave).
interface mem_access_unit_if
   import mem_access_unit_pkg::*;
#(
   parameter int unsigned DATA_W = DefDataW,
   parameter int unsigned ADDR_W = DefAddrW
);
   logic              req;
   logic              we;
   logic [ADDR_W-1:0] addr;
   logic [DATA_W-1:0] wdata;
   logic [DATA_W-1:0] rdata;
   logic              ack;

   modport master (output req, we, addr, wdata, input rdata, ack);
   modport slave  (input req, we, addr, wdata, output rdata, ack);
endinterface

// File: rtl/mem_wait_counter.sv
// Wait-cycle counter for an outstanding access, with terminal count at TIMEOUT_CYC-1.
module mem_wait_counter
   import mem_access_unit_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYC = DefTimeoutCyc
) (
   input  logic clk,
   input  logic rst,
   input  logic clear,
   input  logic enable,
   output logic tc
);
   localparam int unsigned W = wait_cnt_width(TIMEOUT_CYC);

   logic [W-1:0] cnt_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q <= '0;
      end else if (clear) begin
         cnt_q <= '0;
      end else if (enable) begin
         cnt_q <= cnt_q + W'(1);
      end
   end

   if (TIMEOUT_CYC > 0) begin : g_tc
      assign tc = (cnt_q == W'(TIMEOUT_CYC - 1));
   end else begin : g_no_tc
      assign tc = 1'b0;
   end
endmodule

// File: rtl/mem_access_unit.sv
// MAR/MDR memory-access unit: latches address/data from the datapath bus and runs a
// req/ack access to memory, with busy/done status and a sticky timeout error.
module mem_access_unit
   import mem_access_unit_pkg::*;
#(
   parameter int unsigned DATA_W      = DefDataW,
   parameter int unsigned ADDR_W      = DefAddrW,
   parameter int unsigned TIMEOUT_CYC = DefTimeoutCyc
) (
   input  logic              clk,
   input  logic              clr,
   input  logic [DATA_W-1:0] bus_in,
   input  logic              MARin,
   input  logic              MDRin,
   input  logic              read,
   input  logic              write,
   input  logic              err_clr,
   output logic [ADDR_W-1:0] mar_q,
   output logic [DATA_W-1:0] mdr_q,
   output logic              busy,
   output logic              done,
   output logic              err,
   mem_access_unit_if.master mem
);
   state_e state_q;
   logic   start;
   logic   tc;
   logic   timeout;

   assign busy    = (state_q == StAccess);
   assign start   = (state_q == StIdle) && (read || write);
   assign timeout = busy && !mem.ack && tc;

   mem_wait_counter #(
      .TIMEOUT_CYC (TIMEOUT_CYC)
   ) u_wait_counter (
      .clk    (clk),
      .rst    (clr),
      .clear  (start),
      .enable (busy),
      .tc     (tc)
   );

   always_ff @(posedge clk or posedge clr) begin
      if (clr) begin
         state_q   <= StIdle;
         mar_q     <= '0;
         mdr_q     <= '0;
         done      <= 1'b0;
         err       <= 1'b0;
         mem.req   <= 1'b0;
         mem.we    <= 1'b0;
         mem.addr  <= '0;
         mem.wdata <= '0;
      end else begin
         done <= 1'b0;
         unique case (state_q)
            StIdle: begin
               if (MARin) mar_q <= bus_in[ADDR_W-1:0];
               if (MDRin) mdr_q <= bus_in;
               if (read || write) begin
                  // Forward same-cycle bus loads straight into the command
                  state_q   <= StAccess;
                  mem.req   <= 1'b1;
                  mem.we    <= !read;
                  mem.addr  <= MARin ? bus_in[ADDR_W-1:0] : mar_q;
                  mem.wdata <= MDRin ? bus_in : mdr_q;
               end
            end
            StAccess: begin
               if (mem.ack || tc) begin
                  state_q <= StIdle;
                  mem.req <= 1'b0;
                  done    <= 1'b1;
                  if (mem.ack && !mem.we) mdr_q <= mem.rdata;
               end
            end
            default: state_q <= StIdle;
         endcase

         if (timeout) begin
            err <= 1'b1;
         end else if (err_clr) begin
            err <= 1'b0;
         end
      end
   end
endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit: one DUT with the default timeout, one with TIMEOUT_CYC=4.
module tb_mem_access_unit;
   localparam int unsigned DW = 32;
   localparam int unsigned AW = 9;

   logic clk = 1'b0;
   logic clr;
   always #5 clk = ~clk;

   // Main DUT
   logic [DW-1:0] bus_in;
   logic          MARin, MDRin, read, write, err_clr;
   logic [AW-1:0] mar_q;
   logic [DW-1:0] mdr_q;
   logic          busy, done, err;
   mem_access_unit_if #(.DATA_W(DW), .ADDR_W(AW)) m_if ();

   mem_access_unit #(.DATA_W(DW), .ADDR_W(AW), .TIMEOUT_CYC(16)) dut (
      .clk(clk), .clr(clr), .bus_in(bus_in), .MARin(MARin), .MDRin(MDRin),
      .read(read), .write(write), .err_clr(err_clr), .mar_q(mar_q), .mdr_q(mdr_q),
      .busy(busy), .done(done), .err(err), .mem(m_if.master)
   );

   // Short-timeout DUT, memory never acks
   logic          t_read, t_err_clr;
   logic [AW-1:0] t_mar_q;
   logic [DW-1:0] t_mdr_q;
   logic          t_busy, t_done, t_err;
   mem_access_unit_if #(.DATA_W(DW), .ADDR_W(AW)) t_if ();

   mem_access_unit #(.DATA_W(DW), .ADDR_W(AW), .TIMEOUT_CYC(4)) dut_t (
      .clk(clk), .clr(clr), .bus_in('0), .MARin(1'b0), .MDRin(1'b0),
      .read(t_read), .write(1'b0), .err_clr(t_err_clr), .mar_q(t_mar_q), .mdr_q(t_mdr_q),
      .busy(t_busy), .done(t_done), .err(t_err), .mem(t_if.master)
   );

   int checks = 0;
   int errors = 0;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      clr = 1'b1; bus_in = '0; MARin = 0; MDRin = 0; read = 0; write = 0; err_clr = 0;
      m_if.ack = 0; m_if.rdata = '0; t_read = 0; t_err_clr = 0; t_if.ack = 0; t_if.rdata = '0;
      tick(); tick();
      checks++; if ({busy, done, err} !== 3'b000) begin errors++;
         $display("FAIL reset_status: got %b expected 000", {busy, done, err}); end
      checks++; if ({mar_q, mdr_q} !== '0) begin errors++;
         $display("FAIL reset_mar_mdr: got %h/%h expected 0/0", mar_q, mdr_q); end
      checks++; if ({m_if.req, m_if.we, m_if.addr, m_if.wdata} !== '0) begin errors++;
         $display("FAIL reset_mem: got req=%b we=%b addr=%h wdata=%h expected all 0",
                  m_if.req, m_if.we, m_if.addr, m_if.wdata); end
      clr = 1'b0;
      tick();
   endtask

   task automatic test_read_fast();
      bus_in = 32'h5; MARin = 1; tick(); MARin = 0;
      read = 1; tick(); read = 0;  // cycle N+1
      checks++; if ({busy, m_if.req, m_if.we, m_if.addr} !== {1'b1, 1'b1, 1'b0, 9'h005}) begin
         errors++; $display("FAIL read_issue: got busy=%b req=%b we=%b addr=%h expected 1 1 0 005",
                            busy, m_if.req, m_if.we, m_if.addr); end
      m_if.ack = 1; m_if.rdata = 32'hDEADBEEF; tick(); m_if.ack = 0;  // cycle N+2
      checks++; if ({done, busy, m_if.req} !== 3'b100) begin errors++;
         $display("FAIL read_done: got done=%b busy=%b req=%b expected 1 0 0", done, busy, m_if.req); end
      checks++; if (mdr_q !== 32'hDEADBEEF) begin errors++;
         $display("FAIL read_mdr: got %h expected deadbeef", mdr_q); end
      tick();
      checks++; if (done !== 1'b0) begin errors++;
         $display("FAIL read_done_pulse: got %b expected 0", done); end
   endtask

   task automatic test_write_wait();
      bus_in = 32'h12345678; MDRin = 1; tick(); MDRin = 0;
      bus_in = 32'h1F0; MARin = 1; tick(); MARin = 0;
      write = 1; tick(); write = 0;
      for (int k = 1; k <= 4; k++) begin
         checks++;
         if ({m_if.req, m_if.we, m_if.addr, m_if.wdata, done} !== {2'b11, 9'h1F0, 32'h12345678, 1'b0})
         begin errors++;
            $display("FAIL write_hold%0d: got req=%b we=%b addr=%h wdata=%h done=%b expected 1 1 1f0 12345678 0",
                     k, m_if.req, m_if.we, m_if.addr, m_if.wdata, done); end
         if (k == 4) m_if.ack = 1;
         tick();
      end
      m_if.ack = 0;
      checks++; if ({done, m_if.req, err} !== 3'b100) begin errors++;
         $display("FAIL write_done: got done=%b req=%b err=%b expected 1 0 0", done, m_if.req, err); end
      checks++; if (mdr_q !== 32'h12345678) begin errors++;
         $display("FAIL write_mdr: got %h expected 12345678", mdr_q); end
      tick();
      checks++; if (done !== 1'b0) begin errors++;
         $display("FAIL write_done_pulse: got %b expected 0", done); end
   endtask

   task automatic test_forwarding();
      bus_in = 32'h0A; MARin = 1; read = 1; tick(); MARin = 0; read = 0;
      checks++; if ({m_if.addr, mar_q, m_if.we} !== {9'h00A, 9'h00A, 1'b0}) begin errors++;
         $display("FAIL fwd_addr: got addr=%h mar=%h we=%b expected 00a 00a 0",
                  m_if.addr, mar_q, m_if.we); end
      m_if.ack = 1; m_if.rdata = 32'h55; tick(); m_if.ack = 0;
      checks++; if ({done, mdr_q} !== {1'b1, 32'h55}) begin errors++;
         $display("FAIL fwd_read_done: got done=%b mdr=%h expected 1 00000055", done, mdr_q); end
      // Write forwarding, issued in the done cycle of the previous access
      bus_in = 32'hCAFEF00D; MDRin = 1; write = 1; tick(); MDRin = 0; write = 0;
      checks++; if ({m_if.we, m_if.wdata, mdr_q} !== {1'b1, 32'hCAFEF00D, 32'hCAFEF00D}) begin errors++;
         $display("FAIL fwd_wdata: got we=%b wdata=%h mdr=%h expected 1 cafef00d cafef00d",
                  m_if.we, m_if.wdata, mdr_q); end
      m_if.ack = 1; tick(); m_if.ack = 0; tick();
   endtask

   task automatic test_read_wins();
      read = 1; write = 1; tick(); read = 0; write = 0;
      checks++; if ({m_if.req, m_if.we} !== 2'b10) begin errors++;
         $display("FAIL read_wins: got req=%b we=%b expected 1 0", m_if.req, m_if.we); end
      m_if.ack = 1; m_if.rdata = 32'hCAFEF00D; tick(); m_if.ack = 0; tick();
   endtask

   task automatic test_busy_lockout();
      int n_done;
      n_done = 0;
      read = 1; tick(); read = 0;
      bus_in = 32'hFFFFFFFF; MDRin = 1; tick(); MDRin = 0;
      bus_in = 32'h77; MARin = 1; read = 1; tick(); MARin = 0; read = 0;
      checks++; if ({mdr_q, mar_q, m_if.addr, busy} !== {32'hCAFEF00D, 9'h00A, 9'h00A, 1'b1}) begin
         errors++; $display("FAIL lockout_frozen: got mdr=%h mar=%h addr=%h busy=%b expected cafef00d 00a 00a 1",
                            mdr_q, mar_q, m_if.addr, busy); end
      m_if.ack = 1; m_if.rdata = 32'h1111; tick(); m_if.ack = 0;
      for (int k = 0; k < 6; k++) begin
         n_done += int'(done);
         tick();
      end
      checks++; if (n_done !== 1) begin errors++;
         $display("FAIL lockout_done_count: got %0d expected 1", n_done); end
      checks++; if ({busy, m_if.req, mdr_q} !== {2'b00, 32'h1111}) begin errors++;
         $display("FAIL lockout_idle: got busy=%b req=%b mdr=%h expected 0 0 00001111",
                  busy, m_if.req, mdr_q); end
   endtask

   task automatic test_clr_mid_access();
      read = 1; tick(); read = 0;
      checks++; if (m_if.req !== 1'b1) begin errors++;
         $display("FAIL clr_pre_req: got %b expected 1", m_if.req); end
      clr = 1; #1;
      checks++; if ({m_if.req, busy, done, err, mar_q, mdr_q, m_if.addr, m_if.wdata} !== '0) begin
         errors++; $display("FAIL clr_async: got req=%b busy=%b done=%b mar=%h mdr=%h expected all 0",
                            m_if.req, busy, done, mar_q, mdr_q); end
      #1; clr = 0;
      tick();
      checks++; if ({done, busy} !== 2'b00) begin errors++;
         $display("FAIL clr_no_done: got done=%b busy=%b expected 0 0", done, busy); end
      bus_in = 32'h5; MARin = 1; read = 1; tick(); MARin = 0; read = 0;
      m_if.ack = 1; m_if.rdata = 32'hABCD; tick(); m_if.ack = 0;
      checks++; if ({done, mdr_q} !== {1'b1, 32'hABCD}) begin errors++;
         $display("FAIL clr_next_read: got done=%b mdr=%h expected 1 0000abcd", done, mdr_q); end
      tick();
   endtask

   task automatic test_timeout();
      t_read = 1; tick(); t_read = 0;
      for (int k = 1; k <= 4; k++) begin
         checks++; if ({t_if.req, t_done, t_err} !== 3'b100) begin errors++;
            $display("FAIL timeout_req%0d: got req=%b done=%b err=%b expected 1 0 0",
                     k, t_if.req, t_done, t_err); end
         tick();
      end
      checks++; if ({t_if.req, t_done, t_err, t_mdr_q} !== {3'b011, 32'h0}) begin errors++;
         $display("FAIL timeout_exit: got req=%b done=%b err=%b mdr=%h expected 0 1 1 0",
                  t_if.req, t_done, t_err, t_mdr_q); end
      tick();
      checks++; if ({t_done, t_err} !== 2'b01) begin errors++;
         $display("FAIL timeout_sticky: got done=%b err=%b expected 0 1", t_done, t_err); end
      t_err_clr = 1; tick(); t_err_clr = 0;
      checks++; if (t_err !== 1'b0) begin errors++;
         $display("FAIL timeout_err_clr: got %b expected 0", t_err); end
      // err_clr coinciding with the timeout edge must not win
      t_read = 1; tick(); t_read = 0;
      tick(); tick(); tick();
      t_err_clr = 1; tick(); t_err_clr = 0;
      checks++; if ({t_done, t_err} !== 2'b11) begin errors++;
         $display("FAIL timeout_clr_same_cycle: got done=%b err=%b expected 1 1", t_done, t_err); end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      test_reset();
      test_read_fast();
      test_write_wait();
      test_forwarding();
      test_read_wins();
      test_busy_lockout();
      test_clr_mid_access();
      test_timeout();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
